vga_palette_mux: RTL
====================

// Module: vga_palette_mux
// PURPOSE
//  Registered, programmable-palette successor to the fixed 3-bit colour mux. Maps a pixel colour index to
//  RGB through a 2^SELECT_SIZE-entry palette that can be rewritten at runtime. Delays hsync/vsync by the
//  same latency as the RGB path so they leave aligned. Sits between the game renderer and the VGA pins.
// PARAMETERS
//  SELECT_SIZE   3   colour-index width; the palette has 2^SELECT_SIZE entries
//  OUT_RGB_SIZE  4   bits per colour channel; a palette word is 3*OUT_RGB_SIZE bits, {R,G,B}
//  BLINK_FRAMES  30  frames per blink half-period; only used with VGA_PALETTE_BLINK_EN
// PORTS
//  clk_i           in   1                pixel clock
//  rst_i           in   1                synchronous, active-high reset
//  select_i        in   SELECT_SIZE      pixel colour index
//  inActiveArea_i  in   1                1 = visible pixel
//  hsync_i         in   1                horizontal sync from the timing generator
//  vsync_i         in   1                vertical sync from the timing generator
//  pal_we_i        in   1                palette write strobe
//  pal_addr_i      in   SELECT_SIZE      palette write index
//  pal_data_i      in   3*OUT_RGB_SIZE   palette write data {R,G,B}
//  pal_blink_i     in   1                blink flag written with the entry (port present only with the macro)
//  red_o           out  OUT_RGB_SIZE     red channel
//  green_o         out  OUT_RGB_SIZE     green channel
//  blue_o          out  OUT_RGB_SIZE     blue channel
//  hsync_o         out  1                hsync delayed by 2 cycles
//  vsync_o         out  1                vsync delayed by 2 cycles
// BEHAVIOUR
//  - One clock, clk_i; rst_i is synchronous and active-high. While rst_i=1: all RGB outputs 0, hsync_o=0,
//    vsync_o=0, both pipeline stages cleared. The palette reloads its defaults.
//  - Default palette, entry i: R = i[2] ? all-ones : 0; G = i[1] ? all-ones : 0; B = i[0] ? all-ones : 0.
//    Index bits above bit 2 are ignored, so 0=black, 1=blue, 2=green, 4=red, 7=white (a superset of the
//    old fixed map).
//  - Pipeline. Stage 1 registers select, active, hsync and vsync. Stage 2 reads the palette with the
//    stage-1 index and registers RGB. Latency is exactly 2 cycles for RGB and both syncs.
//  - Stage 2 forces RGB to 0 when its active bit is 0, including under rst_i.
//  - Palette write: when pal_we_i=1 at edge t, the entry is updated at t. A lookup of the same index at
//    edge t still gets the old value; the new value is used from edge t+1. There are no write collisions,
//    because there is a single write port.
//  - A write during rst_i is ignored, because reset has priority. Writes are allowed in the active area.
//  - X/unused index values cannot occur because the palette is fully populated.
// CONFIGURATION
//  VGA_PALETTE_BLINK_EN defined:
//  - Each entry gains a blink bit, reset to 0 and written from pal_blink_i.
//  - A frame counter advances on each rising edge of vsync_i, detected with a registered copy of vsync_i.
//  - At count BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles. blink_phase resets to 1
//    (visible).
//  - In stage 2, an entry with its blink bit set outputs RGB 0 while blink_phase=0.
//  - A vsync edge and a palette write in the same cycle are independent.
//  VGA_PALETTE_BLINK_EN undefined:
//  - No pal_blink_i port, no counter, no blink bits. Behaviour is otherwise identical.
// STRUCTURE
//  - vga_pkg holds the colour constants (BLACK, WHITE, RED, GREEN, BLUE) and a function
//    default_entry(index, width) that returns the reset palette word.
//  - One sub-module, vga_palette_regfile: 2^SELECT_SIZE x (3*OUT_RGB_SIZE [+1]) flops, one synchronous
//    write port, one asynchronous read port, sync reset to defaults.
//  - Pipeline and blink logic stay in vga_palette_mux.
// TESTING
//  1. rst_i=1 for 3 cycles with select_i=7, active=1 -> RGB=0, hsync_o=vsync_o=0. After release: select 7
//     -> RGB F/F/F two cycles later.
//  2. Sweep select 0..7 with active=1 -> default map. Each result appears exactly 2 cycles after its index;
//     hsync/vsync pulses are delayed by 2 cycles.
//  3. Write entry 3 = 0x84C at cycle t while select_i=3 at t -> output at t+2 is old 0x0FF; select_i=3 at
//     t+1 -> 0x84C at t+3.
//  4. Toggle inActiveArea_i=0 mid-line with select_i=7 -> RGB=0 for exactly the inactive cycles, shifted
//     by 2.
//  5. Write entry 5 in the same cycle as rst_i=1 -> entry 5 reads the default 0xF0F after reset.
//  6. Blink build, BLINK_FRAMES=2: set the blink bit on entry 4, apply 4 vsync pulses -> red, red, black,
//     black, red pattern per frame pair. Entry 7 stays white throughout.

Source files
------------

// File: rtl/vga_pkg.sv
// Colour constants and reset-palette helper shared by the VGA palette mux and its register file.
package vga_pkg;

   // 3-bit {R,G,B} enable masks; the low three index bits pick channels in the default palette
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] BLUE  = 3'b001;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] WHITE = 3'b111;

   localparam int MAX_WORD = 48;

   // Reset palette word {R,G,B}, each channel all-ones or zero; index bits above bit 2 are ignored
   function automatic logic [MAX_WORD-1:0] default_entry(input int unsigned index,
                                                         input int unsigned width);
      logic [MAX_WORD-1:0] chan;
      logic [MAX_WORD-1:0] word;
      logic [2:0]          idx;
      idx  = index[2:0];
      chan = ~({MAX_WORD{1'b1}} << width);
      word = '0;
      if ((idx & RED)   != BLACK) word = word | (chan << (2 * width));
      if ((idx & GREEN) != BLACK) word = word | (chan << width);
      if ((idx & BLUE)  != BLACK) word = word | chan;
      return word;
   endfunction

endpackage

// File: rtl/vga_palette_regfile.sv
// Palette storage: one synchronous write port, one asynchronous read port, sync reset to defaults.
module vga_palette_regfile
   import vga_pkg::*;
#(
   parameter int SELECT_SIZE  = 3,
   parameter int OUT_RGB_SIZE = 4,
   parameter int WORD_W       = 3 * OUT_RGB_SIZE
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   we,
   input  logic [SELECT_SIZE-1:0] waddr,
   input  logic [WORD_W-1:0]      wdata,
   input  logic [SELECT_SIZE-1:0] raddr,
   output logic [WORD_W-1:0]      rdata
);

   localparam int DEPTH = 1 << SELECT_SIZE;

   logic [WORD_W-1:0] mem [DEPTH];

   // Any bits above the RGB word (blink flag) reset to 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= WORD_W'(default_entry(unsigned'(i), unsigned'(OUT_RGB_SIZE)));
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vga_palette_mux.sv
// Two-stage registered palette lookup with matched hsync/vsync delay.
// Optional per-entry blinking is enabled by defining VGA_PALETTE_BLINK_EN.
module vga_palette_mux
   import vga_pkg::*;
#(
   parameter int SELECT_SIZE  = 3,
   parameter int OUT_RGB_SIZE = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [SELECT_SIZE-1:0]    select_i,
   input  logic                      inActiveArea_i,
   input  logic                      hsync_i,
   input  logic                      vsync_i,
   input  logic                      pal_we_i,
   input  logic [SELECT_SIZE-1:0]    pal_addr_i,
   input  logic [3*OUT_RGB_SIZE-1:0] pal_data_i,
`ifdef VGA_PALETTE_BLINK_EN
   input  logic                      pal_blink_i,
`endif
   output logic [OUT_RGB_SIZE-1:0]   red_o,
   output logic [OUT_RGB_SIZE-1:0]   green_o,
   output logic [OUT_RGB_SIZE-1:0]   blue_o,
   output logic                      hsync_o,
   output logic                      vsync_o
);

   localparam int RGB_W = 3 * OUT_RGB_SIZE;
`ifdef VGA_PALETTE_BLINK_EN
   localparam int WORD_W = RGB_W + 1;
`else
   localparam int WORD_W = RGB_W;
`endif

   logic [SELECT_SIZE-1:0] s1_sel;
   logic                   s1_act, s1_hs, s1_vs;
   logic                   wr_en;
   logic [SELECT_SIZE-1:0] wr_addr;
   logic [WORD_W-1:0]      wr_data;
   logic [WORD_W-1:0]      rd_word;
   logic [RGB_W-1:0]       rgb_q;
   logic                   hs_q, vs_q;
   logic                   blank;

   // Writes are staged alongside stage 1 so a write lines up with the index sampled in the
   // same cycle: that index still sees the old entry, the next one sees the new entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_sel  <= '0;
         s1_act  <= 1'b0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         s1_sel  <= select_i;
         s1_act  <= inActiveArea_i;
         s1_hs   <= hsync_i;
         s1_vs   <= vsync_i;
         wr_en   <= pal_we_i;
         wr_addr <= pal_addr_i;
`ifdef VGA_PALETTE_BLINK_EN
         wr_data <= {pal_blink_i, pal_data_i};
`else
         wr_data <= pal_data_i;
`endif
      end
   end

   vga_palette_regfile #(
      .SELECT_SIZE  (SELECT_SIZE),
      .OUT_RGB_SIZE (OUT_RGB_SIZE),
      .WORD_W       (WORD_W)
   ) u_regfile (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (s1_sel),
      .rdata (rd_word)
   );

`ifdef VGA_PALETTE_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic             vsync_q;
   logic [CNT_W-1:0] frame_cnt;
   logic             blink_phase;

   // Frame count advances on each vsync rising edge; phase flips every BLINK_FRAMES frames
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vsync_q     <= 1'b0;
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else begin
         vsync_q <= vsync_i;
         if (vsync_i && !vsync_q) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   assign blank = !s1_act || (rd_word[RGB_W] && !blink_phase);
`else
   assign blank = !s1_act;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rgb_q <= '0;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         rgb_q <= blank ? '0 : rd_word[RGB_W-1:0];
         hs_q  <= s1_hs;
         vs_q  <= s1_vs;
      end
   end

   assign red_o   = rgb_q[3*OUT_RGB_SIZE-1:2*OUT_RGB_SIZE];
   assign green_o = rgb_q[2*OUT_RGB_SIZE-1:OUT_RGB_SIZE];
   assign blue_o  = rgb_q[OUT_RGB_SIZE-1:0];
   assign hsync_o = hs_q;
   assign vsync_o = vs_q;

endmodule
